// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS main FSM and its datapath.
// The master side is the FSM: it reads IR opcode, decoder class and memory ready, and drives every strobe.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic [2:0] rtypeout;
  logic       memrdy;
  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsource;
  logic       aluop1;
  logic       aluop0;
  logic [3:0] state;
  logic       illegal;

  modport master (
    input  opcode, rtypeout, memrdy,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
           aluop1, aluop0, state, illegal
  );

  modport slave (
    output opcode, rtypeout, memrdy,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
           aluop1, aluop0, state, illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core: one state per cycle, memory states wait on memrdy,
// R-type instructions are routed by the ALU control decoder's class output (normal / brz / jmadd).
module multicycle_control (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_if.master        bus
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    BRZ    = 4'd10,
    JMREAD = 4'd11,
    JMJUMP = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] RT_NORMAL = 3'b100;
  localparam logic [2:0] RT_BRZ    = 3'b001;
  localparam logic [2:0] RT_JMADD  = 3'b010;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Outputs are decoded from the state; only the FETCH write strobes and the illegal pulse
  // also look at the current inputs.
  always_comb begin
    state_d         = FETCH;
    bus.pcwrite     = 1'b0;
    bus.pcwritecond = 1'b0;
    bus.iord        = 1'b0;
    bus.memread     = 1'b0;
    bus.memwrite    = 1'b0;
    bus.irwrite     = 1'b0;
    bus.memtoreg    = 1'b0;
    bus.regdst      = 1'b0;
    bus.regwrite    = 1'b0;
    bus.alusrca     = 1'b0;
    bus.alusrcb     = 2'b00;
    bus.pcsource    = 2'b00;
    bus.aluop1      = 1'b0;
    bus.aluop0      = 1'b0;
    bus.illegal     = 1'b0;

    case (state_q)
      FETCH: begin
        bus.memread = 1'b1;
        bus.alusrcb = 2'b01;
        // The IR/PC update must not fire while reset is held, even though the state already reads FETCH.
        bus.irwrite = bus.memrdy & ~reset;
        bus.pcwrite = bus.memrdy & ~reset;
        state_d     = bus.memrdy ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alusrcb = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          default: begin
            state_d     = FETCH;
            bus.illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        state_d     = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
        state_d     = bus.memrdy ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.regwrite = 1'b1;
        bus.memtoreg = 1'b1;
        state_d      = FETCH;
      end
      MEMWR: begin
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
        state_d      = bus.memrdy ? FETCH : MEMWR;
      end
      EXEC: begin
        bus.alusrca = 1'b1;
        bus.aluop0  = 1'b1;
        case (bus.rtypeout)
          RT_NORMAL: state_d = RWB;
          RT_BRZ:    state_d = BRZ;
          RT_JMADD:  state_d = JMREAD;
          default: begin
            state_d     = FETCH;
            bus.illegal = 1'b1;
          end
        endcase
      end
      RWB: begin
        bus.regwrite = 1'b1;
        bus.regdst   = 1'b1;
        bus.aluop0   = 1'b1;
        state_d      = FETCH;
      end
      BRANCH: begin
        bus.alusrca     = 1'b1;
        bus.aluop1      = 1'b1;
        bus.pcwritecond = 1'b1;
        bus.pcsource    = 2'b01;
        state_d         = FETCH;
      end
      JUMP: begin
        bus.pcwrite  = 1'b1;
        bus.pcsource = 2'b10;
        state_d      = FETCH;
      end
      // aluop stays R-type through brz/jmadd so the decoder keeps selecting the indirect target source.
      BRZ: begin
        bus.pcwritecond = 1'b1;
        bus.pcsource    = 2'b11;
        bus.aluop0      = 1'b1;
        state_d         = FETCH;
      end
      JMREAD: begin
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
        bus.aluop0  = 1'b1;
        state_d     = bus.memrdy ? JMJUMP : JMREAD;
      end
      JMJUMP: begin
        bus.pcwrite  = 1'b1;
        bus.pcsource = 2'b11;
        bus.aluop0   = 1'b1;
        state_d      = FETCH;
      end
      default: begin
        state_d     = FETCH;
        bus.illegal = 1'b1;
      end
    endcase
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for the multicycle main control FSM: expected state sequence goes through a scoreboard queue,
// strobe values are checked with immediate assertions, then a random run checks the exclusion rules.
module tb_multicycle_control;

  logic clk;
  logic reset;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] st;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive memrdy for the coming edge, record the state the FSM must reach, then compare after the edge.
  task automatic step(input logic rdy, input logic [3:0] exp_st, input string tag);
    exp_t e;
    bus.memrdy = rdy;
    e.tag = tag;
    e.st  = exp_st;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check(e.tag, {28'd0, bus.state}, {28'd0, e.st});
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.memrdy   = 1'b1;
    bus.opcode   = 6'b100011;
    bus.rtypeout = 3'b100;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_state",   {28'd0, bus.state},   32'd0);
    check("rst_memread", {31'd0, bus.memread}, 32'd1);
    check("rst_alusrcb", {30'd0, bus.alusrcb}, 32'd1);
    check("rst_irwrite", {31'd0, bus.irwrite}, 32'd0);
    check("rst_pcwrite", {31'd0, bus.pcwrite}, 32'd0);
    check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_irwrite", {31'd0, bus.irwrite}, 32'd1);
    check("rel_pcwrite", {31'd0, bus.pcwrite}, 32'd1);

    // lw with two stall cycles in MEMRD: 0,1,2,3,3,3,4,0
    step(1'b1, 4'd1, "lw_dec");
    step(1'b1, 4'd2, "lw_adr");
    step(1'b1, 4'd3, "lw_rd");
    check("lw_rd_iord",     {31'd0, bus.iord},     32'd1);
    check("lw_rd_regwrite", {31'd0, bus.regwrite}, 32'd0);
    step(1'b0, 4'd3, "lw_stall1");
    step(1'b0, 4'd3, "lw_stall2");
    step(1'b1, 4'd4, "lw_wb");
    check("lw_wb_regwrite", {31'd0, bus.regwrite}, 32'd1);
    check("lw_wb_memtoreg", {31'd0, bus.memtoreg}, 32'd1);
    check("lw_wb_regdst",   {31'd0, bus.regdst},   32'd0);
    step(1'b1, 4'd0, "lw_done");
    check("lw_f_regwrite",  {31'd0, bus.regwrite}, 32'd0);

    // R-type normal: 0,1,6,7,0
    bus.opcode   = 6'b000000;
    bus.rtypeout = 3'b100;
    step(1'b1, 4'd1, "rt_dec");
    step(1'b1, 4'd6, "rt_exec");
    check("rt_exec_aluop", {30'd0, bus.aluop1, bus.aluop0}, 32'd1);
    check("rt_exec_srca",  {31'd0, bus.alusrca},            32'd1);
    step(1'b1, 4'd7, "rt_wb");
    check("rt_wb_regwrite", {31'd0, bus.regwrite}, 32'd1);
    check("rt_wb_regdst",   {31'd0, bus.regdst},   32'd1);
    step(1'b1, 4'd0, "rt_done");

    // brz: 0,1,6,10,0
    bus.rtypeout = 3'b001;
    step(1'b1, 4'd1,  "brz_dec");
    step(1'b1, 4'd6,  "brz_exec");
    step(1'b1, 4'd10, "brz_brz");
    check("brz_pcwritecond", {31'd0, bus.pcwritecond}, 32'd1);
    check("brz_pcsource",    {30'd0, bus.pcsource},    32'd3);
    check("brz_pcwrite",     {31'd0, bus.pcwrite},     32'd0);
    step(1'b1, 4'd0, "brz_done");

    // jmadd with one stall in JMREAD: 0,1,6,11,11,12,0
    bus.rtypeout = 3'b010;
    step(1'b1, 4'd1,  "jm_dec");
    step(1'b1, 4'd6,  "jm_exec");
    step(1'b1, 4'd11, "jm_read");
    check("jm_read_memread", {31'd0, bus.memread}, 32'd1);
    check("jm_read_iord",    {31'd0, bus.iord},    32'd1);
    step(1'b0, 4'd11, "jm_stall");
    step(1'b1, 4'd12, "jm_jump");
    check("jm_jump_pcwrite",  {31'd0, bus.pcwrite},  32'd1);
    check("jm_jump_pcsource", {30'd0, bus.pcsource}, 32'd3);
    step(1'b1, 4'd0, "jm_done");

    // beq: 0,1,8,0
    bus.opcode = 6'b000100;
    step(1'b1, 4'd1, "beq_dec");
    step(1'b1, 4'd8, "beq_br");
    check("beq_aluop1",      {31'd0, bus.aluop1},      32'd1);
    check("beq_pcwritecond", {31'd0, bus.pcwritecond}, 32'd1);
    check("beq_pcsource",    {30'd0, bus.pcsource},    32'd1);
    step(1'b1, 4'd0, "beq_done");

    // Illegal opcode pulses in DECODE then returns to FETCH
    bus.opcode = 6'b111111;
    step(1'b1, 4'd1, "ill_dec");
    check("ill_op_pulse", {31'd0, bus.illegal}, 32'd1);
    step(1'b1, 4'd0, "ill_done");
    check("ill_op_clear", {31'd0, bus.illegal}, 32'd0);

    // Illegal rtypeout in EXEC: pulse, back to FETCH, no register write
    bus.opcode   = 6'b000000;
    bus.rtypeout = 3'b111;
    step(1'b1, 4'd1, "illrt_dec");
    step(1'b1, 4'd6, "illrt_exec");
    check("illrt_pulse",    {31'd0, bus.illegal},  32'd1);
    check("illrt_regwrite", {31'd0, bus.regwrite}, 32'd0);
    step(1'b1, 4'd0, "illrt_done");
    check("illrt_f_regwrite", {31'd0, bus.regwrite}, 32'd0);

    // sw, then an asynchronous reset in the middle of the stalled MEMWR
    bus.opcode   = 6'b101011;
    bus.rtypeout = 3'b100;
    step(1'b1, 4'd1, "sw_dec");
    step(1'b1, 4'd2, "sw_adr");
    step(1'b0, 4'd5, "sw_wr");
    check("sw_memwrite", {31'd0, bus.memwrite}, 32'd1);
    step(1'b0, 4'd5, "sw_stall");
    #2;
    reset = 1'b1;
    #1;
    check("arst_state",    {28'd0, bus.state},    32'd0);
    check("arst_memwrite", {31'd0, bus.memwrite}, 32'd0);
    check("arst_irwrite",  {31'd0, bus.irwrite},  32'd0);
    bus.memrdy = 1'b1;
    bus.opcode = 6'b000010;
    @(posedge clk);
    #1;
    check("arst_hold_state", {28'd0, bus.state},   32'd0);
    check("arst_hold_pcw",   {31'd0, bus.pcwrite}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_rel_irwrite", {31'd0, bus.irwrite}, 32'd1);
    check("arst_rel_pcwrite", {31'd0, bus.pcwrite}, 32'd1);

    // j: 0,1,9,0
    step(1'b1, 4'd1, "j_dec");
    step(1'b1, 4'd9, "j_jump");
    check("j_pcsource", {30'd0, bus.pcsource}, 32'd2);
    check("j_pcwrite",  {31'd0, bus.pcwrite},  32'd1);
    step(1'b1, 4'd0, "j_done");

    check("sb_empty", sb.size(), 32'd0);

    // Random run: strobe exclusion rules every cycle
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: bus.opcode = 6'b100011;
        1: bus.opcode = 6'b101011;
        2: bus.opcode = 6'b000000;
        3: bus.opcode = 6'b000100;
        4: bus.opcode = 6'b000010;
        default: bus.opcode = 6'($urandom);
      endcase
      bus.rtypeout = 3'($urandom);
      bus.memrdy   = 1'($urandom);
      @(posedge clk);
      #1;
      check("inv_mem_rw", {31'd0, bus.memread & bus.memwrite},    32'd0);
      check("inv_pc_wr",  {31'd0, bus.pcwrite & bus.pcwritecond}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
